// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner: synchronizes the 400 Hz divider
// output into a scan tick, blanks anodes for a guard interval between digits.
module seven_seg_scan #(
    parameter int GUARD_CYCLES  = 1000,
    parameter bit BLANK_LEADING = 1'b0
) (
    input  logic        clk_100Mhz,
    input  logic        reset_n,
    input  logic        clk_400Hz,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_out,
    output logic [1:0]  digit_sel
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [17:0] GUARD_LAST = 18'(GUARD_CYCLES - 1);

    state_t      state_r, state_s;
    logic [17:0] guard_cnt_r, guard_cnt_s;
    logic [1:0]  digit_sel_r, digit_sel_s;
    logic [1:0]  next_sel_s;
    logic [3:0]  an_r, an_s;
    logic [6:0]  seg_r, seg_s;
    logic        dp_out_r, dp_out_s;
    logic [15:0] shadow_value_r, shadow_value_s;
    logic [3:0]  shadow_dp_r, shadow_dp_s;
    logic        sync1_r, sync2_r, sync3_r;
    logic        tick_s;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // Digit i >= 1 goes dark when it and every more significant nibble are zero.
    function automatic logic [6:0] digit_pattern(input logic [15:0] val, input logic [1:0] idx);
        logic [3:0] nib;
        logic       blank;
        case (idx)
            2'd0: begin
                nib   = val[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = val[7:4];
                blank = BLANK_LEADING && (val[15:4] == 12'h000);
            end
            2'd2: begin
                nib   = val[11:8];
                blank = BLANK_LEADING && (val[15:8] == 8'h00);
            end
            2'd3: begin
                nib   = val[15:12];
                blank = BLANK_LEADING && (val[15:12] == 4'h0);
            end
            default: begin
                nib   = 4'h0;
                blank = 1'b1;
            end
        endcase
        return blank ? 7'b1111111 : hex_to_seg(nib);
    endfunction

    // Three-flop synchronizer for the asynchronous divider output.
    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= clk_400Hz;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign tick_s     = sync2_r & ~sync3_r;
    assign next_sel_s = digit_sel_r + 2'd1;

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_s        = state_r;
        guard_cnt_s    = guard_cnt_r;
        digit_sel_s    = digit_sel_r;
        an_s           = an_r;
        seg_s          = seg_r;
        dp_out_s       = dp_out_r;
        shadow_value_s = shadow_value_r;
        shadow_dp_s    = shadow_dp_r;
        if (!enable) begin
            state_s     = ST_IDLE;
            guard_cnt_s = 18'd0;
            digit_sel_s = 2'd0;
            an_s        = 4'b1111;
            seg_s       = 7'b1111111;
            dp_out_s    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    shadow_value_s = value;
                    shadow_dp_s    = dp;
                    seg_s          = digit_pattern(value, 2'd0);
                    dp_out_s       = ~dp[0];
                    digit_sel_s    = 2'd0;
                    an_s           = 4'b1111;
                    guard_cnt_s    = 18'd0;
                    state_s        = ST_GUARD;
                end
                ST_GUARD: begin
                    if (guard_cnt_r == GUARD_LAST) begin
                        state_s     = ST_SHOW;
                        an_s        = ~(4'b0001 << digit_sel_r);
                        guard_cnt_s = 18'd0;
                    end else begin
                        an_s        = 4'b1111;
                        guard_cnt_s = guard_cnt_r + 18'd1;
                    end
                end
                ST_SHOW: begin
                    if (tick_s) begin
                        digit_sel_s = next_sel_s;
                        an_s        = 4'b1111;
                        guard_cnt_s = 18'd0;
                        state_s     = ST_GUARD;
                        // A new frame starts on wrap: digit 0 shows the fresh snapshot.
                        if (next_sel_s == 2'd0) begin
                            shadow_value_s = value;
                            shadow_dp_s    = dp;
                            seg_s          = digit_pattern(value, 2'd0);
                            dp_out_s       = ~dp[0];
                        end else begin
                            seg_s          = digit_pattern(shadow_value_r, next_sel_s);
                            dp_out_s       = ~shadow_dp_r[next_sel_s];
                        end
                    end else begin
                        an_s = ~(4'b0001 << digit_sel_r);
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    guard_cnt_s = 18'd0;
                    digit_sel_s = 2'd0;
                    an_s        = 4'b1111;
                    seg_s       = 7'b1111111;
                    dp_out_s    = 1'b1;
                end
            endcase
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            guard_cnt_r    <= 18'd0;
            digit_sel_r    <= 2'd0;
            an_r           <= 4'b1111;
            seg_r          <= 7'b1111111;
            dp_out_r       <= 1'b1;
            shadow_value_r <= 16'h0000;
            shadow_dp_r    <= 4'b0000;
        end else begin
            state_r        <= state_s;
            guard_cnt_r    <= guard_cnt_s;
            digit_sel_r    <= digit_sel_s;
            an_r           <= an_s;
            seg_r          <= seg_s;
            dp_out_r       <= dp_out_s;
            shadow_value_r <= shadow_value_s;
            shadow_dp_r    <= shadow_dp_s;
        end
    end

    assign an        = an_r;
    assign seg       = seg_r;
    assign dp_out    = dp_out_r;
    assign digit_sel = digit_sel_r;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: one instance without and one with
// leading-zero blanking, both driven by the same stimulus.
module tb_seven_seg_scan;

    logic        clk_100Mhz;
    logic        reset_n;
    logic        clk_400Hz;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_out_a, dp_out_b;
    logic [1:0]  digit_sel_a, digit_sel_b;
    logic [13:0] obs_a, obs_b;
    logic [13:0] exp_prev;
    int          checks;
    int          errors;

    localparam logic [13:0] RESET_PK = {4'b1111, 7'b1111111, 1'b1, 2'd0};

    seven_seg_scan #(.GUARD_CYCLES(4), .BLANK_LEADING(1'b0)) dut_a (
        .clk_100Mhz(clk_100Mhz), .reset_n(reset_n), .clk_400Hz(clk_400Hz),
        .enable(enable), .value(value), .dp(dp),
        .an(an_a), .seg(seg_a), .dp_out(dp_out_a), .digit_sel(digit_sel_a)
    );

    seven_seg_scan #(.GUARD_CYCLES(4), .BLANK_LEADING(1'b1)) dut_b (
        .clk_100Mhz(clk_100Mhz), .reset_n(reset_n), .clk_400Hz(clk_400Hz),
        .enable(enable), .value(value), .dp(dp),
        .an(an_b), .seg(seg_b), .dp_out(dp_out_b), .digit_sel(digit_sel_b)
    );

    assign obs_a = {an_a, seg_a, dp_out_a, digit_sel_a};
    assign obs_b = {an_b, seg_b, dp_out_b, digit_sel_b};

    initial clk_100Mhz = 1'b0;
    always #5 clk_100Mhz = ~clk_100Mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_100Mhz);
            #1;
        end
    endtask

    // Called right after the edge that entered GUARD: three more blank cycles, then SHOW.
    task automatic guard_to_show(input string tag, input logic [13:0] exp_a, input logic [13:0] exp_b);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check({tag, "_guard_an"}, 32'(an_a), 32'(4'b1111));
        end
        step(1);
        check({tag, "_show_a"}, 32'(obs_a), 32'(exp_a));
        check({tag, "_show_b"}, 32'(obs_b), 32'(exp_b));
        exp_prev = exp_a;
    endtask

    task automatic scan_digit(input string tag, input logic [3:0] exp_an, input logic [1:0] sel,
                              input logic [6:0] sa, input logic [6:0] sb, input logic dpo);
        clk_400Hz = 1'b1;
        step(2);
        check({tag, "_early"}, 32'(obs_a), 32'(exp_prev));
        step(1);
        check({tag, "_enter_a"}, 32'(obs_a), 32'({4'b1111, sa, dpo, sel}));
        check({tag, "_enter_b"}, 32'(obs_b), 32'({4'b1111, sb, dpo, sel}));
        clk_400Hz = 1'b0;
        guard_to_show(tag, {exp_an, sa, dpo, sel}, {exp_an, sb, dpo, sel});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_prev  = RESET_PK;
        reset_n   = 1'b0;
        clk_400Hz = 1'b0;
        enable    = 1'b1;
        value     = 16'hFFFF;
        dp        = 4'b0000;
        step(3);
        check("reset_a", 32'(obs_a), 32'(RESET_PK));
        check("reset_b", 32'(obs_b), 32'(RESET_PK));

        reset_n = 1'b1;
        step(1);
        check("start_enter", 32'(obs_a), 32'({4'b1111, 7'b0001110, 1'b1, 2'd0}));
        guard_to_show("start", {4'b1110, 7'b0001110, 1'b1, 2'd0}, {4'b1110, 7'b0001110, 1'b1, 2'd0});

        // Old FFFF frame finishes; the wrap captures 1234.
        value = 16'h1234;
        dp    = 4'b0100;
        scan_digit("f0d1", 4'b1101, 2'd1, 7'b0001110, 7'b0001110, 1'b1);
        scan_digit("f0d2", 4'b1011, 2'd2, 7'b0001110, 7'b0001110, 1'b1);
        scan_digit("f0d3", 4'b0111, 2'd3, 7'b0001110, 7'b0001110, 1'b1);
        scan_digit("f1d0", 4'b1110, 2'd0, 7'b0011001, 7'b0011001, 1'b1);
        scan_digit("f1d1", 4'b1101, 2'd1, 7'b0110000, 7'b0110000, 1'b1);
        scan_digit("f1d2", 4'b1011, 2'd2, 7'b0100100, 7'b0100100, 1'b0);
        scan_digit("f1d3", 4'b0111, 2'd3, 7'b1111001, 7'b1111001, 1'b1);
        scan_digit("f2d0", 4'b1110, 2'd0, 7'b0011001, 7'b0011001, 1'b1);
        scan_digit("f2d1", 4'b1101, 2'd1, 7'b0110000, 7'b0110000, 1'b1);

        // Mid-frame value change must not tear the current frame.
        value = 16'hABCD;
        scan_digit("snap_d2", 4'b1011, 2'd2, 7'b0100100, 7'b0100100, 1'b0);
        scan_digit("snap_d3", 4'b0111, 2'd3, 7'b1111001, 7'b1111001, 1'b1);
        scan_digit("f3d0", 4'b1110, 2'd0, 7'b0100001, 7'b0100001, 1'b1);
        scan_digit("f3d1", 4'b1101, 2'd1, 7'b1000110, 7'b1000110, 1'b1);
        scan_digit("f3d2", 4'b1011, 2'd2, 7'b0000011, 7'b0000011, 1'b0);
        scan_digit("f3d3", 4'b0111, 2'd3, 7'b0001000, 7'b0001000, 1'b1);

        // Leading-zero blanking on instance b.
        value = 16'h0050;
        dp    = 4'b1000;
        scan_digit("blk_d0", 4'b1110, 2'd0, 7'b1000000, 7'b1000000, 1'b1);
        scan_digit("blk_d1", 4'b1101, 2'd1, 7'b0010010, 7'b0010010, 1'b1);
        scan_digit("blk_d2", 4'b1011, 2'd2, 7'b1000000, 7'b1111111, 1'b1);
        scan_digit("blk_d3", 4'b0111, 2'd3, 7'b1000000, 7'b1111111, 1'b0);
        value = 16'h0000;
        dp    = 4'b0000;
        scan_digit("zero_d0", 4'b1110, 2'd0, 7'b1000000, 7'b1000000, 1'b1);
        scan_digit("zero_d1", 4'b1101, 2'd1, 7'b1000000, 7'b1111111, 1'b1);
        scan_digit("zero_d2", 4'b1011, 2'd2, 7'b1000000, 7'b1111111, 1'b1);

        // Enable drop while showing digit 2.
        enable = 1'b0;
        step(1);
        check("dis_a", 32'(obs_a), 32'(RESET_PK));
        check("dis_b", 32'(obs_b), 32'(RESET_PK));
        step(1);
        check("dis_hold", 32'(obs_a), 32'(RESET_PK));

        value  = 16'h5678;
        dp     = 4'b0001;
        enable = 1'b1;
        step(1);
        check("ren_enter", 32'(obs_a), 32'({4'b1111, 7'b0000000, 1'b0, 2'd0}));
        // This tick lands inside GUARD and must be ignored.
        clk_400Hz = 1'b1;
        guard_to_show("ren", {4'b1110, 7'b0000000, 1'b0, 2'd0}, {4'b1110, 7'b0000000, 1'b0, 2'd0});
        clk_400Hz = 1'b0;
        step(3);
        check("ren_hold", 32'(obs_a), 32'(exp_prev));
        scan_digit("ren_d1", 4'b1101, 2'd1, 7'b1111000, 7'b1111000, 1'b1);

        // Asynchronous reset mid-scan clears outputs before the next edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_a", 32'(obs_a), 32'(RESET_PK));
        check("areset_b", 32'(obs_b), 32'(RESET_PK));
        step(2);
        reset_n = 1'b1;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Four-digit multiplexed seven-segment driver for the 16-bit CPU's display path, directly downstream of the 400 Hz display clock divider.
- Consumes the divider's 400 Hz square wave as a level input and turns each rising edge into a one-cycle scan tick in the 100 MHz domain.
- On each tick it advances the active digit, decodes the hex nibble and drives active-low anodes, segments and decimal point.
- A guard interval blanks the anodes between digits to stop ghosting. A per-frame snapshot of the displayed value prevents tearing.

Parameters:
- GUARD_CYCLES, 1000, clk_100Mhz cycles with all anodes off after each digit change. Legal range is 1..249999; the block is unspecified outside it.
- BLANK_LEADING, 0, when 1 leading zero digits are blanked. Digit 0 is never blanked.

Ports:
- clk_100Mhz  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous active-low reset
- clk_400Hz  in  1  divider output, treated as an asynchronous level and synchronized internally
- enable  in  1  display on when 1
- value  in  16  hex value to show; value[3:0] goes on digit 0 (rightmost)
- dp  in  4  decimal point request per digit, active-high; dp[i] belongs to digit i
- an  out  4  anode enables, active-low; an[i] drives digit i
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}
- dp_out  out  1  decimal point, active-low
- digit_sel  out  2  index of the current digit

Behaviour:
- Reset (reset_n=0, asynchronous) sets:
  - an=4'b1111, seg=7'b1111111, dp_out=1, digit_sel=0
  - state=IDLE, sync flops=0, guard counter=0, shadow regs=0
- Synchronizer and tick:
  - clk_400Hz passes through sync1 -> sync2 -> sync3.
  - tick = sync2 & ~sync3, exactly one cycle wide.
  - A rising edge sampled at edge k produces tick high in the cycle after edge k+1.
  - Ticks arrive every 250000 cycles, so each digit refreshes at 100 Hz.
- IDLE state:
  - Outputs are held at their reset values and digit_sel=0.
  - If enable=1, on the next edge: snapshot value/dp into the shadow regs, load digit 0 decode, go to GUARD.
- GUARD state:
  - an=1111 while seg/dp_out already carry the new digit's pattern.
  - The counter runs from 0 to GUARD_CYCLES-1, then the state becomes SHOW.
  - Ticks arriving in GUARD are ignored.
- SHOW state:
  - an has only bit digit_sel low.
  - On tick: digit_sel increments with wrap 3->0, an goes to 1111, seg/dp_out load the next digit, guard counter clears, state becomes GUARD. All of this happens on one edge.
  - When digit_sel wraps 3->0, the shadow regs capture value/dp on that same edge, and digit 0 decodes the newly captured value.
- enable=0 in any state: the next edge forces IDLE with outputs at reset values. enable is sampled every cycle.
- Decode table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit i≥1 shows seg=1111111 when shadow nibbles i..3 are all zero.
  - dp_out still follows the shadow dp[i].
- dp_out = ~shadow_dp[digit_sel].
- All outputs are registered. No combinational path runs from inputs to outputs.
- Asserting reset mid-scan returns the block to IDLE immediately, with no partial digit left driven.

Test Plan:
- Reset: hold reset_n=0 with enable=1 and value=16'hFFFF -> an=1111, seg=1111111, dp_out=1, digit_sel=0. Release -> GUARD entered on the first edge with enable=1, an stays 1111 for GUARD_CYCLES cycles, then an=1110 and seg=0001110 (F).
- Scan order: GUARD_CYCLES=4, value=16'h1234, dp=4'b0100, clk_400Hz toggling every 20 cycles.
  - Successive SHOW phases give an=1110/1101/1011/0111 with seg=0011001/0110000/0100100/1111001.
  - dp_out=0 only while digit_sel=2.
  - an=1111 for exactly 4 cycles between digits.
- Tick latency: apply a clk_400Hz rising edge sampled at edge k while in SHOW -> an=1111 and digit_sel advanced at edge k+2.
- Snapshot: change value from 16'h1234 to 16'hABCD while digit_sel=1 -> digits 2 and 3 still show 2 and 1. Next frame shows D, C, b, A.
- Blanking: BLANK_LEADING=1, value=16'h0050, dp=4'b1000 -> digits 3 and 2 blank with dp_out=0 on digit 3, digit 1 shows 5, digit 0 shows 0. value=16'h0000 -> only digit 0 lit, showing 0.
- Enable drop: deassert enable mid-SHOW on digit 2 -> next edge an=1111, seg=1111111, digit_sel=0. Reassert -> scan restarts at digit 0 with a fresh snapshot.
